protein_seq_decoder: RTL and testbench
======================================

// Module: protein_seq_decoder
// PURPOSE
//  Input front end of the aligner. Takes an ASCII byte stream (FASTA-style residue letters),
//  decodes each letter to datatypesPkg::protein_base and buffers the result in a FIFO.
//  Emits a valid/ready stream of residues, with the last residue of each sequence flagged.
//  This stream feeds the sequence buffers ahead of blosum_compare.
// PARAMETERS
//  MAX_LEN     1024  max residues per sequence (matches `MAX_LEN1/`MAX_LEN2)
//  FIFO_DEPTH  16    output FIFO entries, power of two, >=2
// PORTS
//  clk         in   1                     single clock, rising edge
//  rst_n       in   1                     asynchronous, active-low reset
//  in_valid    in   1                     in_data holds a byte
//  in_ready    out  1                     byte accepted when in_valid && in_ready
//  in_data     in   8                     ASCII byte
//  out_valid   out  1                     out_base/out_last valid
//  out_ready   in   1                     residue consumed when out_valid && out_ready
//  out_base    out  protein_base          decoded residue
//  out_last    out  1                     final residue of the sequence
//  seq_done    out  1                     1-cycle pulse when a last residue enters the FIFO
//  seq_len     out  $clog2(MAX_LEN+1)     residue count of the sequence just closed (valid with seq_done, held after)
//  err_clr     in   1                     synchronous clear of the sticky error flags
//  err_char    out  1                     sticky: illegal byte seen
//  err_ovf     out  1                     sticky: sequence exceeded MAX_LEN
// BEHAVIOUR
//  Byte classes:
//   - 'A'-'Z' / 'a'-'z': letter. Decodes to the same-named protein_base; case-insensitive.
//   - 0x0A, 0x0D, 0x00: terminator.
//   - 0x20, 0x09: whitespace, skipped silently.
//   - Any other byte: skipped, and err_char is set.
//  One-residue hold register delays each decoded letter until the next byte class is known,
//  so out_last is known at push time.
//  FSM, evaluated only on an accepted byte:
//   - EMPTY + letter -> HOLD (hold letter; count=1).
//   - EMPTY + terminator -> EMPTY. No push, no seq_done; empty sequences are dropped.
//   - HOLD + letter, count<MAX_LEN -> HOLD. Push held residue with last=0; hold new letter; count++.
//   - HOLD + letter, count==MAX_LEN -> DROP. Push held residue with last=1; seq_done pulse;
//     seq_len=MAX_LEN; set err_ovf; new letter discarded.
//   - HOLD + terminator -> EMPTY. Push held residue with last=1; seq_done pulse; seq_len=count.
//   - DROP + letter -> DROP (discard).
//   - DROP + terminator -> EMPTY.
//  Flow control:
//   - in_ready = !fifo_full in all states. No push/pop bypass: a full FIFO blocks input
//     even if it is popping that same cycle.
//   - At most one push per accepted byte, so an accepted byte always fits.
//  Latency: a letter reaches out_valid one cycle after the byte following it is accepted.
//  FIFO: show-ahead, so out_base/out_last are the head entry and out_valid=!empty.
//   - Push and pop in the same cycle are both performed.
//   - Pointers are log2(FIFO_DEPTH)+1 bits; full/empty are detected from the wrap bit.
//  err_clr and a same-cycle error set: set wins.
//  Reset (async assert, sync deassert handled at top level):
//   - FSM=EMPTY; count=0; FIFO empty.
//   - out_valid=0, out_base=A, out_last=0, seq_done=0, seq_len=0, err_char=0, err_ovf=0.
//   - in_ready=1 after reset.
//   - Reset mid-sequence discards the held residue and all FIFO contents.
// STRUCTURE
//  datatypesPkg additions:
//   - function ascii_to_base(logic [7:0]) -> protein_base
//   - function is_letter/is_term/is_space(logic [7:0]) -> logic
//   - localparams ASCII_LF=8'h0A, ASCII_CR=8'h0D, ASCII_NUL=8'h00
//   - typedef enum {DEC_EMPTY, DEC_HOLD, DEC_DROP} dec_state_t
//  Sub-module: seq_fifo #(WIDTH=$bits(protein_base)+1, DEPTH=FIFO_DEPTH), a generic
//  show-ahead sync FIFO, reusable for the score path.
// TESTING
//  1. "ACGT\n", out_ready=1 -> out A,C,G,T; out_last only on T; seq_done once, seq_len=4.
//  2. "ac\r" -> A,C with last on C. "\n\n\0" -> no outputs, no seq_done, no errors.
//  3. "A1 B\n" -> A,B (last on B); err_char=1 and stays 1; err_clr pulse -> 0.
//     Space alone does not set err_char.
//  4. MAX_LEN=4, "ABCDEF\nG\n" -> A,B,C,D (last D, seq_len=4), err_ovf=1; E,F dropped;
//     then G (last, seq_len=1).
//  5. FIFO_DEPTH=4, out_ready=0, 8 letters streamed -> in_ready drops after the 4th push.
//     Release out_ready -> all letters out in order, none lost or duplicated.
//  6. rst_n low for 1 cycle mid-"ABCDE" (async, between edges) -> outputs at reset values
//     immediately. "XY\n" afterwards -> X,Y only.

Source files
------------

// File: rtl/protein_seq_decoder_pkg.sv
// Shared types and ASCII helpers for the protein input front end.
// protein_base encodes the residue letter as its offset from 'A'.
package protein_seq_decoder_pkg;

  typedef enum logic [4:0] {
    A, B, C, D, E, F, G, H, I, J, K, L, M,
    N, O, P, Q, R, S, T, U, V, W, X, Y, Z
  } protein_base;

  typedef enum logic [1:0] {DEC_EMPTY, DEC_HOLD, DEC_DROP} dec_state_t;

  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_TAB = 8'h09;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == ASCII_LF) || (c == ASCII_CR) || (c == ASCII_NUL);
  endfunction

  function automatic logic is_space(input logic [7:0] c);
    return (c == ASCII_SP) || (c == ASCII_TAB);
  endfunction

  // Clearing bit 5 folds lowercase onto uppercase before offsetting from 'A'.
  function automatic protein_base ascii_to_base(input logic [7:0] c);
    if (is_letter(c)) return protein_base'(5'((c & 8'hDF) - 8'h41));
    return A;
  endfunction

endpackage

// File: rtl/protein_seq_decoder_fifo.sv
// Generic show-ahead synchronous FIFO; head entry is always visible on pop_data.
// Pointers carry one extra wrap bit to tell full from empty.
module seq_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/protein_seq_decoder.sv
// ASCII residue stream decoder: classifies bytes, frames sequences and
// buffers decoded residues with an end-of-sequence flag in an output FIFO.
module protein_seq_decoder
  import protein_seq_decoder_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 1024,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output protein_base                  out_base,
  output logic                         out_last,
  output logic                         seq_done,
  output logic [$clog2(MAX_LEN+1)-1:0] seq_len,
  input  logic                         err_clr,
  output logic                         err_char,
  output logic                         err_ovf
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned FW = $bits(protein_base) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  dec_state_t       state;
  logic [CW-1:0]    count;
  protein_base      hold_base;

  logic             accept;
  logic             letter;
  logic             term;
  logic             space;
  logic             push;
  logic             push_last;
  logic             char_bad;
  logic             ovf_hit;
  logic [FW-1:0]    head;
  logic             fifo_full;
  logic             fifo_empty;

  assign accept   = in_valid && in_ready;
  assign letter   = is_letter(in_data);
  assign term     = is_term(in_data);
  assign space    = is_space(in_data);
  assign char_bad = accept && !letter && !term && !space;
  assign ovf_hit  = push && push_last && letter;

  // The held residue is pushed only once the following byte decides its last flag.
  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    if (accept && (state == DEC_HOLD)) begin
      if (letter) begin
        push      = 1'b1;
        push_last = (count == MAX_CNT);
      end else if (term) begin
        push      = 1'b1;
        push_last = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DEC_EMPTY;
      count     <= '0;
      hold_base <= A;
      seq_done  <= 1'b0;
      seq_len   <= '0;
      err_char  <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      if (accept) begin
        case (state)
          DEC_EMPTY: begin
            if (letter) begin
              state     <= DEC_HOLD;
              hold_base <= ascii_to_base(in_data);
              count     <= CW'(1);
            end
          end
          DEC_HOLD: begin
            if (letter) begin
              if (count == MAX_CNT) begin
                state    <= DEC_DROP;
                seq_done <= 1'b1;
                seq_len  <= MAX_CNT;
              end else begin
                hold_base <= ascii_to_base(in_data);
                count     <= count + 1'b1;
              end
            end else if (term) begin
              state    <= DEC_EMPTY;
              seq_done <= 1'b1;
              seq_len  <= count;
            end
          end
          DEC_DROP: begin
            if (term) state <= DEC_EMPTY;
          end
          default: state <= DEC_EMPTY;
        endcase
      end
      err_char <= char_bad || (err_char && !err_clr);
      err_ovf  <= ovf_hit || (err_ovf && !err_clr);
    end
  end

  seq_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({push_last, hold_base}),
    .pop       (out_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign out_base  = fifo_empty ? A : protein_base'(head[FW-2:0]);
  assign out_last  = !fifo_empty && head[FW-1];

endmodule

// File: tb/tb_protein_seq_decoder.sv
// Scoreboard bench for protein_seq_decoder with small MAX_LEN / FIFO_DEPTH
// so overflow and back-pressure are reachable with short vectors.
module tb_protein_seq_decoder;
  import protein_seq_decoder_pkg::*;

  localparam int unsigned TB_MAX_LEN = 4;
  localparam int unsigned TB_DEPTH   = 4;
  localparam int unsigned LW         = $clog2(TB_MAX_LEN + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          out_ready = 1'b0;
  logic          err_clr = 1'b0;
  logic          in_ready;
  logic          out_valid;
  protein_base   out_base;
  logic          out_last;
  logic          seq_done;
  logic [LW-1:0] seq_len;
  logic          err_char;
  logic          err_ovf;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];
  int         exp_len_q[$];
  logic [5:0] mon_exp;
  int         mon_len;

  protein_seq_decoder #(
    .MAX_LEN    (TB_MAX_LEN),
    .FIFO_DEPTH (TB_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_base  (out_base),
    .out_last  (out_last),
    .seq_done  (seq_done),
    .seq_len   (seq_len),
    .err_clr   (err_clr),
    .err_char  (err_char),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic expect_res(input protein_base b, input logic l);
    exp_q.push_back({l, b});
  endtask

  task automatic expect_done(input int len);
    exp_len_q.push_back(len);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int unsigned n;
    bit ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %02h not accepted, required acceptance within 100 cycles", b);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || exp_len_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({name, "_residues_left"}, exp_q.size(), 0);
    check({name, "_done_left"}, exp_len_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_base"}, out_base, A);
    check({name, "_out_last"}, out_last, 0);
    check({name, "_seq_done"}, seq_done, 0);
    check({name, "_seq_len"}, seq_len, 0);
    check({name, "_err_char"}, err_char, 0);
    check({name, "_err_ovf"}, err_ovf, 0);
    check({name, "_in_ready"}, in_ready, 1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands something out.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got base=%0d last=%0b, required no output", out_base, out_last);
          end else begin
            mon_exp = exp_q.pop_front();
            if ({out_last, out_base} !== mon_exp) begin
              errors++;
              $display("FAIL out_residue: got base=%0d last=%0b, required base=%0d last=%0b",
                       out_base, out_last, mon_exp[4:0], mon_exp[5]);
            end
          end
        end
        if (seq_done) begin
          checks++;
          if (exp_len_q.size() == 0) begin
            errors++;
            $display("FAIL seq_done_unexpected: got seq_len=%0d, required no seq_done", seq_len);
          end else begin
            mon_len = exp_len_q.pop_front();
            if (32'(seq_len) !== mon_len) begin
              errors++;
              $display("FAIL seq_len: got %0d required %0d", seq_len, mon_len);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // 1: basic sequence
    expect_res(A, 0); expect_res(C, 0); expect_res(G, 0); expect_res(T, 1);
    expect_done(4);
    send_str("ACGT\n");
    drain("t1");

    // 2: lowercase with CR; bare terminators produce nothing
    expect_res(A, 0); expect_res(C, 1);
    expect_done(2);
    send_str("ac\r");
    send_str("\n\n");
    send(8'h00);
    drain("t2");
    check("t2_err_char", err_char, 0);
    check("t2_err_ovf", err_ovf, 0);

    // 3: illegal byte sets sticky err_char, space skipped silently
    expect_res(A, 0); expect_res(B, 1);
    expect_done(2);
    send_str("A1 B\n");
    drain("t3");
    check("t3_err_char_set", err_char, 1);
    repeat (3) @(negedge clk);
    check("t3_err_char_sticky", err_char, 1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("t3_err_char_clr", err_char, 0);
    send_str(" \t\n");
    @(negedge clk);
    check("t3_space_no_err", err_char, 0);
    @(posedge clk); #1;

    // 4: overflow at MAX_LEN=4
    expect_res(A, 0); expect_res(B, 0); expect_res(C, 0); expect_res(D, 1);
    expect_done(4);
    expect_res(G, 1);
    expect_done(1);
    send_str("ABCDEF\nG\n");
    drain("t4");
    check("t4_err_ovf", err_ovf, 1);
    check("t4_err_char", err_char, 0);

    // 5: back-pressure with a 4-entry FIFO
    out_ready = 1'b0;
    expect_res(A, 0); expect_res(B, 0); expect_res(C, 0); expect_res(D, 1);
    expect_done(4);
    expect_res(E, 0); expect_res(F, 0); expect_res(G, 0); expect_res(H, 1);
    expect_done(4);
    send_str("ABCD");
    @(negedge clk);
    check("t5_ready_before_full", in_ready, 1);
    @(posedge clk); #1;
    send(8'h0A);
    @(negedge clk);
    check("t5_ready_full", in_ready, 0);
    check("t5_out_valid", out_valid, 1);
    in_valid = 1'b1;
    in_data  = "E";
    repeat (3) @(negedge clk);
    check("t5_ready_still_full", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_str("EFGH\n");
    drain("t5");

    // 6: async reset mid-sequence discards everything
    check("t6_err_ovf_before", err_ovf, 1);
    out_ready = 1'b0;
    send_str("ABC");
    in_valid = 1'b1;
    in_data  = "D";
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    expect_res(X, 0); expect_res(Y, 1);
    expect_done(2);
    send_str("XY\n");
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
